// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcodes, state encoding and widths for the ALU issue stage.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int WIDTH = 4;
    localparam int OPW   = 3;
    localparam int CNT_W = 4;

    localparam logic [OPW-1:0] OP_ADD  = 3'd0;
    localparam logic [OPW-1:0] OP_SUB  = 3'd1;
    localparam logic [OPW-1:0] OP_XOR  = 3'd2;
    localparam logic [OPW-1:0] OP_SLT  = 3'd3;
    localparam logic [OPW-1:0] OP_AND  = 3'd4;
    localparam logic [OPW-1:0] OP_NAND = 3'd5;
    localparam logic [OPW-1:0] OP_NOR  = 3'd6;
    localparam logic [OPW-1:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : alu_settle_counter
// Brief    : Loadable down-counter; last flags the final settle cycle (count==1).
// Revision : 1.0
// ============================================================================
module alu_settle_counter
    import alu_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] cnt;

    // Parks at 1 once reached; the next load restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (en && (cnt > CW'(1))) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign count = cnt;
    assign last  = (cnt == CW'(1));

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Brief    : Registers ALU operands, holds them for SETTLE_CYCLES, then captures
//            result and flags into a valid/ready output register.
// Revision : 1.0
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH         = alu_pkg::WIDTH,
    parameter int OPW           = alu_pkg::OPW,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carryout,
    output logic             out_overflow,
    output logic             out_zero,
    output logic [OPW-1:0]   out_op
);

    state_t           state;
    logic             accept;
    logic             cnt_last;
    logic [CNT_W-1:0] settle_count;

    // rst_n gates in_ready so nothing is offered as accepted while reset is held.
    assign in_ready = rst_n && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

    alu_settle_counter #(
        .CW (CNT_W)
    ) u_settle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_value (CNT_W'(SETTLE_CYCLES)),
        .en         (state == S_SETTLE),
        .count      (settle_count),
        .last       (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_op       <= '0;
        end else begin
            if (accept) begin
                alu_a  <= in_a;
                alu_b  <= in_b;
                alu_op <= in_op;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_last) begin
                        out_valid    <= 1'b1;
                        out_result   <= alu_result;
                        out_carryout <= alu_carryout;
                        out_overflow <= alu_overflow;
                        out_zero     <= (alu_result == '0);
                        out_op       <= alu_op;
                        state        <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Drain and a new accept may share one edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? S_SETTLE : S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
